// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

  localparam int INSTR_W     = 32;
  localparam int ADDR_W      = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    ERROR  = 2'd3
  } state_e;

endpackage

// File: rtl/ifetch_pc_gen.sv
// PC register, next-pc selection (redirect / +4 / hold) and range/alignment checking.
// err pulses on a bad redirect target or an attempt to fetch from a bad pc.
module ifetch_pc_gen
  import ifetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                MEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              redir_en,
  input  logic [ADDR_W-1:0] redir_pc,
  input  logic              adv_en,
  output logic [ADDR_W-1:0] pc,
  output logic              err
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_WORDS * INSTR_BYTES);

  logic [ADDR_W-1:0] pc_q, pc_d;

  function automatic logic addr_bad(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] != 2'b00) || (addr >= ADDR_LIMIT);
  endfunction

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    pc_d = pc_q;
    err  = 1'b0;
    if (redir_en) begin
      // The bad target is still loaded; pc then freezes there in ERROR.
      pc_d = redir_pc;
      err  = addr_bad(redir_pc);
    end else if (adv_en) begin
      if (addr_bad(pc_q)) err  = 1'b1;
      else                pc_d = pc_q + ADDR_W'(INSTR_BYTES);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc_q <= RESET_PC;
    else          pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: FSM and decode-side output register around ifetch_pc_gen.
// Define IFETCH_PERF_EN to add saturating perf_fetched / perf_bubbles counters.
module instr_fetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter int                MEM_WORDS = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               fetch_err
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles
`endif
);

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
  logic               fetch_err_q, fetch_err_d;

  logic              adv, redir_en, adv_en, pc_err;
  logic [ADDR_W-1:0] pc;

  // The output slot can take a new word when it is empty or being accepted.
  assign adv      = !out_valid_q || out_ready;
  assign redir_en = redirect_valid && (state_q == RUN || state_q == HALTED);
  assign adv_en   = (state_q == RUN) && !redirect_valid && adv;

  ifetch_pc_gen #(
    .RESET_PC  (RESET_PC),
    .MEM_WORDS (MEM_WORDS)
  ) u_pc_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .redir_en (redir_en),
    .redir_pc (redirect_pc),
    .adv_en   (adv_en),
    .pc       (pc),
    .err      (pc_err)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    fetch_err_d = fetch_err_q;
    unique case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (redirect_valid) begin
          out_valid_d = 1'b0;
          if (pc_err) begin
            fetch_err_d = 1'b1;
            state_d     = ERROR;
          end
        end else if (adv) begin
          if (pc_err) begin
            out_valid_d = 1'b0;
            fetch_err_d = 1'b1;
            state_d     = ERROR;
          end else begin
            out_valid_d = 1'b1;
            out_instr_d = imem_instr;
            out_pc_d    = pc;
            if (halt) state_d = HALTED;
          end
        end else if (halt) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        if (redirect_valid) begin
          out_valid_d = 1'b0;
          if (pc_err) begin
            fetch_err_d = 1'b1;
            state_d     = ERROR;
          end else begin
            state_d = RUN;
          end
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      ERROR: if (out_valid_q && out_ready) out_valid_d = 1'b0;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the data registers are reset too, so decode never sees stale contents after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign imem_addr = pc;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign fetch_err = fetch_err_q;

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_bubbles_q, perf_bubbles_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_bubbles_d = perf_bubbles_q;
    if (out_valid_q && out_ready && !(&perf_fetched_q))
      perf_fetched_d = perf_fetched_q + 32'd1;
    if (state_q == RUN && !out_valid_q && !(&perf_bubbles_q))
      perf_bubbles_d = perf_bubbles_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: scenario tasks push expected (pc, instr)
// pairs; a negedge monitor pops and compares them on every accepted handshake.
module tb_instr_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fetch_err;

  logic [31:0] mem [0:1023];
  exp_t        exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .MEM_WORDS (1024)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fetch_err      (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_word(input logic [31:0] addr);
    return (addr < 32'd4096) ? mem[addr[11:2]] : 32'hDEAD_BEEF;
  endfunction

  assign imem_instr = exp_word(imem_addr);

  task automatic push_exp(input logic [31:0] addr);
    exp_t e;
    e.pc    = addr;
    e.instr = exp_word(addr);
    exp_q.push_back(e);
  endtask

  // Inputs change 1 time unit after the rising edge; checks run just after the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got pc=%h instr=%h, required no transfer", out_pc, out_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_pc !== e.pc || out_instr !== e.instr) begin
          n_bad++;
          $display("FAIL sb_transfer: got pc=%h instr=%h, required pc=%h instr=%h",
                   out_pc, out_instr, e.pc, e.instr);
        end
      end
    end
  end

  task automatic do_reset();
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
    out_ready      = 1'b1;
    tick();
    tick();
    exp_q.delete();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_pc !== 32'h0) begin n_bad++; $display("FAIL rst_pc: got %h want 0", out_pc); end
    n_cmp++; if (out_instr !== 32'h0) begin n_bad++; $display("FAIL rst_instr: got %h want 0", out_instr); end
    n_cmp++; if (fetch_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", fetch_err); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
    tick();
    sample();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL seq_first_bubble: got %b want 0", out_valid); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL seq_first_addr: got %h want 0", imem_addr); end
    repeat (4) tick();
    sample();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL seq_pending: got %0d left want 0", exp_q.size()); end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h8);
    repeat (3) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (out_pc !== 32'h4) begin n_bad++; $display("FAIL stall_pc[%0d]: got %h want 4", i, out_pc); end
      n_cmp++; if (out_instr !== exp_word(32'h4)) begin n_bad++; $display("FAIL stall_instr[%0d]: got %h want %h", i, out_instr, exp_word(32'h4)); end
      n_cmp++; if (imem_addr !== 32'h8) begin n_bad++; $display("FAIL stall_addr[%0d]: got %h want 8", i, imem_addr); end
      tick();
    end
    out_ready = 1'b1;
    sample();
    tick();
    sample();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL stall_pending: got %0d left want 0", exp_q.size()); end
    n_cmp++; if (out_pc !== 32'h8) begin n_bad++; $display("FAIL stall_resume_pc: got %h want 8", out_pc); end
    // Asynchronous reset in mid-cycle must clear everything at once.
    reset_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL async_rst_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_pc !== 32'h0) begin n_bad++; $display("FAIL async_rst_pc: got %h want 0", out_pc); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL async_rst_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_redirect();
    do_reset();
    push_exp(32'h0);
    repeat (3) tick();
    out_ready = 1'b0;
    tick();
    sample();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin n_bad++; $display("FAIL redir_held: got valid=%b pc=%h want 1/4", out_valid, out_pc); end
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    push_exp(32'h40);
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    sample();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL redir_bubble: got %b want 0", out_valid); end
    n_cmp++; if (imem_addr !== 32'h40) begin n_bad++; $display("FAIL redir_addr: got %h want 40", imem_addr); end
    tick();
    sample();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL redir_pending: got %0d left want 0", exp_q.size()); end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_redirect_err(input logic [31:0] bad_pc);
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = bad_pc;
    tick();
    redirect_valid = 1'b0;
    sample();
    n_cmp++; if (fetch_err !== 1'b1) begin n_bad++; $display("FAIL rerr_flag(%h): got %b want 1", bad_pc, fetch_err); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rerr_valid(%h): got %b want 0", bad_pc, out_valid); end
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rerr_stuck_valid(%h)[%0d]: got %b want 0", bad_pc, i, out_valid); end
      n_cmp++; if (fetch_err !== 1'b1) begin n_bad++; $display("FAIL rerr_stuck_flag(%h)[%0d]: got %b want 1", bad_pc, i, fetch_err); end
      tick();
    end
    n_cmp++; if (imem_addr !== bad_pc) begin n_bad++; $display("FAIL rerr_frozen_pc(%h): got %h", bad_pc, imem_addr); end
  endtask

  task automatic test_range_end();
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFF0;
    for (int i = 0; i < 4; i++) push_exp(32'hFF0 + 32'(i * 4));
    tick();
    redirect_valid = 1'b0;
    repeat (4) tick();
    sample();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL end_pending: got %0d left want 0", exp_q.size()); end
    n_cmp++; if (fetch_err !== 1'b0) begin n_bad++; $display("FAIL end_early_err: got %b want 0", fetch_err); end
    n_cmp++; if (imem_addr !== 32'h1000) begin n_bad++; $display("FAIL end_pc: got %h want 1000", imem_addr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      sample();
      n_cmp++; if (fetch_err !== 1'b1) begin n_bad++; $display("FAIL end_err[%0d]: got %b want 1", i, fetch_err); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL end_valid[%0d]: got %b want 0", i, out_valid); end
    end
    n_cmp++; if (imem_addr !== 32'h1000) begin n_bad++; $display("FAIL end_no_wrap: got %h want 1000", imem_addr); end
  endtask

  task automatic test_halt();
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    halt           = 1'b1;
    push_exp(32'h20);
    push_exp(32'h24);
    tick();
    redirect_valid = 1'b0;
    halt           = 1'b0;
    tick();
    tick();
    halt = 1'b1;
    push_exp(32'h28);
    sample();
    tick();
    halt = 1'b0;
    sample();
    tick();
    sample();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL halt_pending: got %0d left want 0", exp_q.size()); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL halt_valid: got %b want 0", out_valid); end
    n_cmp++; if (imem_addr !== 32'h2C) begin n_bad++; $display("FAIL halt_pc: got %h want 2c", imem_addr); end
    repeat (2) tick();
    sample();
    n_cmp++; if (out_valid !== 1'b0 || imem_addr !== 32'h2C) begin n_bad++; $display("FAIL halt_frozen: got valid=%b pc=%h want 0/2c", out_valid, imem_addr); end
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8;
    push_exp(32'h8);
    tick();
    redirect_valid = 1'b0;
    sample();
    n_cmp++; if (out_valid !== 1'b0 || imem_addr !== 32'h8) begin n_bad++; $display("FAIL halt_resume_bubble: got valid=%b pc=%h want 0/8", out_valid, imem_addr); end
    tick();
    sample();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL halt_resume_pending: got %0d left want 0", exp_q.size()); end
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + 32'(i) * 32'h0001_0003;
    reset_n        = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
    out_ready      = 1'b1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_err(32'h42);
    test_redirect_err(32'h1000);
    test_range_end();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
